// File: rtl/spi_cs_sequencer_if.sv
// Handshake bundle between upstream byte source, the CS sequencer and the SPI master byte engine.
// The master modport is the side that feeds bytes in and models the engine; slave is the sequencer.
interface spi_cs_sequencer_if #(
    parameter int CW = 2
);
    logic [CW-1:0] tx_count;
    logic [7:0]    tx_byte;
    logic          tx_dv;
    logic          tx_ready;

    logic [7:0]    m_tx_byte;
    logic          m_tx_dv;
    logic          m_tx_ready;
    logic          m_rx_dv;
    logic [7:0]    m_rx_byte;

    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic [CW-1:0] rx_count;
    logic          spi_cs_n;

    modport master (
        output tx_count, tx_byte, tx_dv, m_tx_ready, m_rx_dv, m_rx_byte,
        input  tx_ready, m_tx_byte, m_tx_dv, rx_dv, rx_byte, rx_count, spi_cs_n
    );

    modport slave (
        input  tx_count, tx_byte, tx_dv, m_tx_ready, m_rx_dv, m_rx_byte,
        output tx_ready, m_tx_byte, m_tx_dv, rx_dv, rx_byte, rx_count, spi_cs_n
    );
endinterface

// File: rtl/spi_cs_sequencer.sv
// Chip-select sequencer in front of an SPI master byte engine: frames multi-byte transactions
// with an active-low CS, enforces CS hold/inactive times and tags received bytes with their index.
module spi_cs_sequencer #(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int CS_HOLD_CLKS     = 2,
    parameter int CS_INACTIVE_CLKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    spi_cs_sequencer_if.slave  bus
);
    localparam int CW   = $clog2(MAX_BYTES_PER_CS + 1);
    localparam int TMAX = (CS_HOLD_CLKS > CS_INACTIVE_CLKS) ? CS_HOLD_CLKS : CS_INACTIVE_CLKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    if (CS_HOLD_CLKS < 1)     $error("CS_HOLD_CLKS must be at least 1");
    if (CS_INACTIVE_CLKS < 1) $error("CS_INACTIVE_CLKS must be at least 1");
    if (MAX_BYTES_PER_CS < 1) $error("MAX_BYTES_PER_CS must be at least 1");

    typedef enum logic [1:0] {
        IDLE,
        TRANSFER,
        CS_HOLD,
        CS_INACTIVE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] remaining;
    logic          pending;
    logic [TW-1:0] timer;
    logic          cs_n;

    logic          slot_open;
    logic          accept;
    logic          first_accept;
    logic          last_done;

    logic          vld_p1;
    logic [7:0]    rx_byte_p1;
    logic [CW-1:0] rx_idx_p1;

    // A count of zero still moves one byte; anything past the frame limit is cut to the limit.
    function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] cnt);
        if (cnt == '0) begin
            return CW'(1);
        end else if (cnt > CW'(MAX_BYTES_PER_CS)) begin
            return CW'(MAX_BYTES_PER_CS);
        end else begin
            return cnt;
        end
    endfunction

    function automatic logic [CW-1:0] sat_inc_idx(input logic [CW-1:0] idx);
        if (idx == CW'(MAX_BYTES_PER_CS - 1)) begin
            return idx;
        end else begin
            return idx + CW'(1);
        end
    endfunction

    // slot_open is the ready condition before the DV gating; acceptance is judged against it
    // so the visible tx_ready can drop in the same cycle a DV is presented.
    always_comb begin
        slot_open = 1'b0;
        unique case (state)
            IDLE:        slot_open = bus.m_tx_ready;
            TRANSFER:    slot_open = ~pending & bus.m_tx_ready & (remaining != '0);
            CS_HOLD:     slot_open = 1'b0;
            CS_INACTIVE: slot_open = 1'b0;
            default:     slot_open = 1'b0;
        endcase
        if (rst) begin
            slot_open = 1'b0;
        end
    end

    assign accept       = bus.tx_dv & slot_open;
    assign first_accept = accept & (state == IDLE);
    assign last_done    = (state == TRANSFER) & ~pending & bus.m_tx_ready & (remaining == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:        if (accept)        state_nxt = TRANSFER;
            TRANSFER:    if (last_done)     state_nxt = CS_HOLD;
            CS_HOLD:     if (timer == '0)   state_nxt = CS_INACTIVE;
            CS_INACTIVE: if (timer == '0)   state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.tx_ready  = slot_open & ~bus.tx_dv;
        bus.m_tx_dv   = accept;
        bus.m_tx_byte = bus.tx_byte;
        bus.spi_cs_n  = cs_n;
        bus.rx_dv     = vld_p1;
        bus.rx_byte   = rx_byte_p1;
        bus.rx_count  = rx_idx_p1;
    end

    // The pending flag covers the cycle where the master still shows ready after taking a DV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n      <= 1'b1;
            remaining <= '0;
            pending   <= 1'b0;
            timer     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cs_n      <= 1'b0;
                        remaining <= clamp_count(bus.tx_count) - CW'(1);
                        pending   <= 1'b1;
                    end
                end
                TRANSFER: begin
                    if (accept) begin
                        remaining <= remaining - CW'(1);
                        pending   <= 1'b1;
                    end else if (~bus.m_tx_ready) begin
                        pending   <= 1'b0;
                    end
                    if (last_done) begin
                        timer <= TW'(CS_HOLD_CLKS - 1);
                    end
                end
                CS_HOLD: begin
                    if (timer == '0) begin
                        cs_n  <= 1'b1;
                        timer <= TW'(CS_INACTIVE_CLKS - 1);
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                CS_INACTIVE: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    cs_n <= 1'b1;
                end
            endcase
        end
    end

    // ---- stage p0 -> p1: received byte register; index advances after each visible pulse ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            rx_byte_p1 <= '0;
            rx_idx_p1  <= '0;
        end else begin
            vld_p1 <= bus.m_rx_dv;
            if (bus.m_rx_dv) begin
                rx_byte_p1 <= bus.m_rx_byte;
            end
            if (first_accept) begin
                rx_idx_p1 <= '0;
            end else if (vld_p1) begin
                rx_idx_p1 <= sat_inc_idx(rx_idx_p1);
            end
        end
    end
endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Directed bench for spi_cs_sequencer: the bench plays both the upstream byte source and the
// SPI master engine handshake, applying per-cycle vectors with hand-derived expected outputs.
module tb_spi_cs_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_cs_sequencer_if #(.CW(2)) bus ();

    spi_cs_sequencer #(
        .MAX_BYTES_PER_CS(2),
        .CS_HOLD_CLKS    (2),
        .CS_INACTIVE_CLKS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       dv;
        logic [1:0] cnt;
        logic [7:0] byt;
        logic       mrdy;
        logic       mrxdv;
        logic [7:0] mrxb;
        logic       e_rdy;
        logic       e_mdv;
        logic       e_cs;
        logic       e_rxdv;
        logic [7:0] e_rxb;
        logic [1:0] e_rxc;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;
    vec_t tbl [28];

    function automatic vec_t mk(input logic dv, input logic [1:0] cnt, input logic [7:0] byt,
                                input logic mrdy, input logic mrxdv, input logic [7:0] mrxb,
                                input logic e_rdy, input logic e_mdv, input logic e_cs,
                                input logic e_rxdv, input logic [7:0] e_rxb, input logic [1:0] e_rxc);
        vec_t v;
        v.dv = dv; v.cnt = cnt; v.byt = byt; v.mrdy = mrdy; v.mrxdv = mrxdv; v.mrxb = mrxb;
        v.e_rdy = e_rdy; v.e_mdv = e_mdv; v.e_cs = e_cs; v.e_rxdv = e_rxdv;
        v.e_rxb = e_rxb; v.e_rxc = e_rxc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.tx_dv      = v.dv;
        bus.tx_count   = v.cnt;
        bus.tx_byte    = v.byt;
        bus.m_tx_ready = v.mrdy;
        bus.m_rx_dv    = v.mrxdv;
        bus.m_rx_byte  = v.mrxb;
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        chk({tag, " tx_ready"},  {7'd0, bus.tx_ready}, {7'd0, v.e_rdy});
        chk({tag, " m_tx_dv"},   {7'd0, bus.m_tx_dv},  {7'd0, v.e_mdv});
        chk({tag, " m_tx_byte"}, bus.m_tx_byte,        v.byt);
        chk({tag, " cs_n"},      {7'd0, bus.spi_cs_n}, {7'd0, v.e_cs});
        chk({tag, " rx_dv"},     {7'd0, bus.rx_dv},    {7'd0, v.e_rxdv});
        chk({tag, " rx_byte"},   bus.rx_byte,          v.e_rxb);
        chk({tag, " rx_count"},  {6'd0, bus.rx_count}, {6'd0, v.e_rxc});
    endtask

    initial begin
        // single byte 0xC1: CS falls on accept, rises two cycles after the master's ready returns
        tbl[0]  = mk(0, 0, 8'h00, 1, 0, 8'h00,  1, 0, 1, 0, 8'h00, 0);
        tbl[1]  = mk(1, 1, 8'hC1, 1, 0, 8'h00,  0, 1, 1, 0, 8'h00, 0);
        tbl[2]  = mk(0, 0, 8'h00, 1, 0, 8'h00,  0, 0, 0, 0, 8'h00, 0);
        tbl[3]  = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00, 0);
        tbl[4]  = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00, 0);
        tbl[5]  = mk(0, 0, 8'h00, 1, 1, 8'hC1,  0, 0, 0, 0, 8'h00, 0);
        tbl[6]  = mk(0, 0, 8'h00, 1, 0, 8'h00,  0, 0, 0, 1, 8'hC1, 0);
        tbl[7]  = mk(0, 0, 8'h00, 1, 0, 8'h00,  0, 0, 0, 0, 8'hC1, 1);
        for (int i = 8; i < 12; i++) tbl[i] = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 8'hC1, 1);
        tbl[12] = mk(0, 0, 8'h00, 1, 0, 8'h00,  1, 0, 1, 0, 8'hC1, 1);
        // two bytes 0xBE, 0xEF in one CS frame, immediately after the first transaction
        tbl[13] = mk(1, 2, 8'hBE, 1, 0, 8'h00,  0, 1, 1, 0, 8'hC1, 1);
        tbl[14] = mk(0, 0, 8'h00, 1, 0, 8'h00,  0, 0, 0, 0, 8'hC1, 0);
        tbl[15] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 0, 0, 8'hC1, 0);
        tbl[16] = mk(0, 0, 8'h00, 1, 1, 8'hBE,  1, 0, 0, 0, 8'hC1, 0);
        tbl[17] = mk(1, 0, 8'hEF, 1, 0, 8'h00,  0, 1, 0, 1, 8'hBE, 0);
        tbl[18] = mk(0, 0, 8'h00, 1, 0, 8'h00,  0, 0, 0, 0, 8'hBE, 1);
        tbl[19] = mk(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 0, 0, 8'hBE, 1);
        tbl[20] = mk(0, 0, 8'h00, 1, 1, 8'hEF,  0, 0, 0, 0, 8'hBE, 1);
        tbl[21] = mk(0, 0, 8'h00, 1, 0, 8'h00,  0, 0, 0, 1, 8'hEF, 1);
        tbl[22] = mk(0, 0, 8'h00, 1, 0, 8'h00,  0, 0, 0, 0, 8'hEF, 1);
        for (int i = 23; i < 27; i++) tbl[i] = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 8'hEF, 1);
        tbl[27] = mk(0, 0, 8'h00, 1, 0, 8'h00,  1, 0, 1, 0, 8'hEF, 1);

        rst = 1'b1;
        drive(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0));
        repeat (2) @(negedge clk);
        chk("reset cs_n",     {7'd0, bus.spi_cs_n}, 8'h01);
        chk("reset tx_ready", {7'd0, bus.tx_ready}, 8'h00);
        chk("reset rx_dv",    {7'd0, bus.rx_dv},    8'h00);
        chk("reset rx_byte",  bus.rx_byte,          8'h00);
        chk("reset rx_count", {6'd0, bus.rx_count}, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // count=3 clamps to two bytes; DVs while not ready never reach the master
        apply("clamp1", mk(1, 3, 8'h11, 1, 0, 8'h00, 0, 1, 1, 0, 8'hEF, 1));
        apply("clamp2", mk(1, 0, 8'h99, 1, 0, 8'h00, 0, 0, 0, 0, 8'hEF, 0));
        apply("clamp3", mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'hEF, 0));
        apply("midbyte_dv", mk(1, 0, 8'h98, 0, 0, 8'h00, 0, 0, 0, 0, 8'hEF, 0));
        apply("clamp5", mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 8'hEF, 0));
        apply("clamp6", mk(1, 0, 8'h22, 1, 0, 8'h00, 0, 1, 0, 0, 8'hEF, 0));
        apply("clamp7", mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'hEF, 0));
        apply("third_dv", mk(1, 0, 8'h33, 1, 0, 8'h00, 0, 0, 0, 0, 8'hEF, 0));
        apply("clamp_hold1", mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'hEF, 0));
        apply("clamp_hold2", mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'hEF, 0));
        for (int i = 0; i < 4; i++)
            apply($sformatf("clamp_inact%0d", i), mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 8'hEF, 0));
        apply("clamp_idle", mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 0, 8'hEF, 0));

        // count=0 behaves as a single byte
        apply("zero1", mk(1, 0, 8'hA5, 1, 0, 8'h00, 0, 1, 1, 0, 8'hEF, 0));
        apply("zero2", mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'hEF, 0));
        apply("zero3", mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'hEF, 0));
        apply("zero4", mk(0, 0, 8'h00, 1, 1, 8'hA5, 0, 0, 0, 0, 8'hEF, 0));
        apply("zero5", mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0));
        apply("zero6", mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 1));
        for (int i = 0; i < 4; i++)
            apply($sformatf("zero_inact%0d", i), mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 1));
        apply("zero_idle", mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 0, 8'hA5, 1));

        // reset in the middle of a byte
        apply("rst1", mk(1, 1, 8'h5A, 1, 0, 8'h00, 0, 1, 1, 0, 8'hA5, 1));
        apply("rst2", mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 0));
        apply("rst3", mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 0));
        @(posedge clk);
        #1;
        bus.tx_dv      = 1'b1;
        bus.m_tx_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst cs_n",     {7'd0, bus.spi_cs_n}, 8'h01);
        chk("midrst tx_ready", {7'd0, bus.tx_ready}, 8'h00);
        chk("midrst m_tx_dv",  {7'd0, bus.m_tx_dv},  8'h00);
        chk("midrst rx_byte",  bus.rx_byte,          8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.tx_dv = 1'b0;
        #1;
        chk("postrst tx_ready", {7'd0, bus.tx_ready}, 8'h01);
        chk("postrst cs_n",     {7'd0, bus.spi_cs_n}, 8'h01);

        apply("after1", mk(1, 1, 8'h3C, 1, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0));
        apply("after2", mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        apply("after3", mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        apply("after4", mk(0, 0, 8'h00, 1, 1, 8'h3C, 0, 0, 0, 0, 8'h00, 0));
        apply("after5", mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1, 8'h3C, 0));
        apply("after6", mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'h3C, 1));
        apply("after7", mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 8'h3C, 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
